// File: rtl/npc_pkg.sv
// Shared types and constants for the npc core front end.
package npc_pkg;

   localparam int unsigned XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      ERR  = 2'd2
   } ifu_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-to-decode valid/ready channel carrying one {pc, inst} entry.
interface ifu_fetch_if;
   import npc_pkg::*;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_inst;

   modport master (output out_valid, output out_pc, output out_inst, input out_ready);
   modport slave  (input out_valid, input out_pc, input out_inst, output out_ready);

endinterface

// File: rtl/ifu_fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush overrides push/pop.
module ifu_fifo
   import npc_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  fetch_entry_t               din,
   output fetch_entry_t               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked entirely by cnt.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign count = cnt;
   assign full  = (cnt == DEPTH_C);
   assign empty = (cnt == '0);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, buffers {pc, inst} pairs, handles redirect/halt.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC  = npc_pkg::RESET_PC,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst_data,
   ifu_fetch_if.master dec,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        fetch_err,
   output logic        halted
);
   import npc_pkg::*;

   localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

   ifu_state_e   state;
   ifu_state_e   state_next;
   logic [31:0]  pc;
   logic         misaligned;
   logic         fire_in;
   logic         pop;
   logic         full;
   logic         empty;
   logic [CW-1:0] count;
   fetch_entry_t push_entry;
   fetch_entry_t head;

   assign misaligned = (redirect_pc[1:0] != 2'b00);

   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            if (redirect_valid)  state_next = misaligned ? ERR : RUN;
            else if (halt_req)   state_next = HALT;
         end
         HALT: begin
            if (redirect_valid)  state_next = misaligned ? ERR : RUN;
         end
         default: state_next = ERR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_next;
   end

   // A full buffer may still accept a fetch when decode drains the head this cycle.
   always_comb begin
      dec.out_valid = !empty && !redirect_valid && (state != ERR);
      dec.out_pc    = head.pc;
      dec.out_inst  = head.inst;
      pop           = dec.out_valid && dec.out_ready;
      fire_in       = (state == RUN) && !redirect_valid && !halt_req && (!full || pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         if (!misaligned && state != ERR) pc <= redirect_pc;
      end else if (fire_in) begin
         pc <= pc + 32'd4;
      end
   end

   assign push_entry = '{pc: pc, inst: inst_data};

   ifu_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fire_in),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (push_entry),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CW'(BUF_DEPTH));

   assign inst_addr = pc;
   assign fetch_err = (state == ERR);
   assign halted    = (state == HALT);

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit: owns the PC and drives the byte address into the combinational instruction ROM. The ROM returns inst_data in the same cycle.
- Captures each {pc, inst} pair in a small FIFO and presents it to decode over a valid/ready handshake.
- Accepts redirects (jump/branch/resume) from later stages, and halt requests.
- Sits between the instruction ROM and the decode stage of the npc core.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- inst_addr  out  32  byte fetch address to ROM; always equals the PC register
- inst_data  in  32  ROM read data for inst_addr, same cycle
- out_valid  out  1  head entry is presentable to decode
- out_ready  in  1  decode accepts the head entry
- out_pc  out  32  PC of the head entry
- out_inst  out  32  instruction of the head entry
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new PC
- halt_req  in  1  stop fetching (e.g. ebreak); single-cycle pulse or level
- fetch_err  out  1  sticky misaligned-redirect error
- halted  out  1  FSM is in HALT

Behaviour:
- Clock and reset:
  - One clock, clk. rst is asynchronous and active-high.
  - Reset values: pc=RESET_PC, FIFO empty, state=RUN, out_valid=0, fetch_err=0, halted=0.
  - out_pc and out_inst are don't-care while out_valid=0.
  - inst_addr shows RESET_PC while rst is asserted.
- FSM states:
  - RUN → HALT on halt_req (no redirect that cycle).
  - RUN or HALT → ERR on redirect_valid with redirect_pc[1:0]≠0.
  - HALT → RUN on an aligned redirect.
  - ERR is exited only by rst.
- fire_in (fetch): state==RUN && !redirect_valid && !halt_req && (count<BUF_DEPTH || pop).
  - On fire_in: push {pc, inst_data}; pc <= pc+4, 32-bit wrap.
  - Otherwise pc holds.
- Pop handshake:
  - out_valid = !empty && !redirect_valid && state!=ERR.
  - pop = out_valid && out_ready.
- Latency: an entry fetched at edge N is visible at out_* after edge N (one cycle). With out_ready=1, throughput is one instruction per cycle.
- Full FIFO with pop in the same cycle: push and pop are both allowed, and count is unchanged.
- Empty FIFO: out_valid=0. There is no bypass from ROM to output.
- Redirect (highest priority):
  - Flushes all FIFO entries at the edge.
  - out_valid is forced to 0 in the redirect cycle, so no handshake completes.
  - Aligned redirect: pc <= redirect_pc, state <= RUN.
  - Misaligned redirect: pc unchanged, fetch_err <= 1, state <= ERR.
- halt_req:
  - No fetch in that cycle or after.
  - Already-buffered entries still drain to decode.
  - halted=1 in HALT.
  - If halt_req and redirect_valid occur together, redirect wins.
- ERR: no fetch, out_valid=0, FIFO contents ignored.
- Reset mid-operation: all state clears immediately (asynchronous). Fetch restarts at RESET_PC on the first edge after rst deasserts.
- Width rules: pc arithmetic is 32-bit unsigned, wraps 0xFFFF_FFFC → 0x0000_0000. FIFO pointers are log2(BUF_DEPTH) bits with a separate count of log2(BUF_DEPTH)+1 bits.

Decomposition:
- Shared package npc_pkg:
  - XLEN=32
  - RESET_PC constant
  - ifu_state_e enum {RUN, HALT, ERR}
  - fetch_entry_t struct {pc[31:0], inst[31:0]}
- One sub-module, ifu_fifo: synchronous FIFO of fetch_entry_t.
  - Ports: clk, rst, push, pop, flush, din, dout, full, empty, count.
  - flush has priority over push/pop.
  - Reusable by later pipeline stages.

Test Plan:
- Reset, out_ready=1, ROM preloaded → out_pc sequence 0x80000000, 0x80000004, 0x80000008, 0x8000000C on consecutive cycles; first out_valid one cycle after rst release; out_inst matches ROM words.
- out_ready=0 from reset → FIFO holds 2 entries; inst_addr stalls at 0x80000008. Raise out_ready → 0x80000000, 0x80000004, 0x80000008 in order with no loss or duplication.
- FIFO full, redirect_valid=1 with redirect_pc=0x80000040, out_ready=1 same cycle → out_valid=0 that cycle and no handshake; next outputs 0x80000040, 0x80000044; stale entries never appear.
- halt_req at pc=0x80000010 → halted=1; buffered entries drain; inst_addr frozen. Redirect to 0x80000100 → halted=0; next out_pc=0x80000100.
- Redirect to 0x80000042 → fetch_err=1 after the edge; out_valid stays 0 for 20 cycles; rst pulse mid-cycle clears fetch_err asynchronously and fetch resumes at 0x80000000.
- Random out_ready/redirect/halt (10k cycles) vs. reference model → out_pc stream matches the model exactly; count never exceeds BUF_DEPTH.
